// File: rtl/text_fetch.sv
// text_fetch: walks 8x8 cells of the text grid, reads one char code per cell line from text RAM
// and presents char/column/row/blank pixel-aligned, two cycles after i_active is sampled.
module text_fetch #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_active,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_rd,
  input  logic [7:0]        i_ram_data,
  output logic [7:0]        o_char,
  output logic [2:0]        o_column,
  output logic [2:0]        o_row,
  output logic              o_blank
);
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  typedef enum logic {IDLE, FRAME} state_t;
  state_t state, state_n;
  logic [2:0] px, py, px_c, py_c, px1, py1, px2, py2;
  logic [CW-1:0] col, col_c;
  logic [RW-1:0] row, row_c;
  logic [ADDR_W-1:0] row_base, base_c;
  logic active_d, in_text, rd_c, v1, v2, rd_d;
  logic [7:0] char_hold;
  // A frame-start pixel is fetched as the first cell of the frame.
  always_comb begin
    state_n = i_frame_start ? FRAME : state;
    px_c    = i_frame_start ? '0 : px;
    py_c    = i_frame_start ? '0 : py;
    col_c   = i_frame_start ? '0 : col;
    row_c   = i_frame_start ? '0 : row;
    base_c  = i_frame_start ? '0 : row_base;
    in_text = (state == FRAME || i_frame_start) && i_active && col_c < CW'(COLS) && row_c < RW'(ROWS);
    rd_c    = in_text && px_c == 3'd0;
  end
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      px <= '0;
      py <= '0;
      col <= '0;
      row <= '0;
      row_base <= '0;
      active_d <= 1'b0;
    end else begin
      active_d <= i_active;
      if (i_frame_start) begin
        px <= '0;
        py <= '0;
        col <= '0;
        row <= '0;
        row_base <= '0;
      end else if (state == FRAME) begin
        if (i_active) begin
          px <= px + 3'd1;
          if (px == 3'd7 && col < CW'(COLS)) col <= col + CW'(1);
        end else if (active_d) begin
          px <= '0;
          col <= '0;
          py <= py + 3'd1;
          if (py == 3'd7 && row < RW'(ROWS)) begin
            row <= row + RW'(1);
            row_base <= row_base + ADDR_W'(COLS);
          end
        end
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ram_rd <= 1'b0;
      o_ram_addr <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      rd_d <= 1'b0;
      px1 <= '0;
      py1 <= '0;
      px2 <= '0;
      py2 <= '0;
      char_hold <= '0;
      o_char <= '0;
      o_column <= '0;
      o_row <= '0;
      o_blank <= 1'b1;
    end else begin
      o_ram_rd <= rd_c;
      if (rd_c) o_ram_addr <= base_c + ADDR_W'(col_c);
      v1 <= in_text;
      px1 <= px_c;
      py1 <= py_c;
      rd_d <= o_ram_rd;
      v2 <= v1;
      px2 <= px1;
      py2 <= py1;
      if (rd_d) char_hold <= i_ram_data;
      o_char <= rd_d ? i_ram_data : char_hold;
      o_column <= px2;
      o_row <= py2;
      o_blank <= ~v2;
    end
  end
endmodule

// File: tb/tb_text_fetch.sv
// tb_text_fetch: drives frames/lines and compares every cycle against a pixel/line position model.
module tb_text_fetch;
  logic clk = 0, rst = 0, fs = 0, act = 0;
  logic [12:0] addr;
  logic rd, bl;
  logic [7:0] ram_q = 0, ch;
  logic [2:0] cl, rw;
  int vecs = 0, errs = 0;
  bit frame = 0, act_d = 0;
  int x = 0, line = 0;
  logic [12:0] e_addr = 0;
  bit e_rd = 0;
  logic [7:0] last = 0;
  typedef struct {bit b; logic [7:0] c; logic [2:0] col; logic [2:0] row;} pix_t;
  pix_t pq[3];
  always #5 clk = ~clk;
  text_fetch dut (.i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_active(act), .o_ram_addr(addr),
    .o_ram_rd(rd), .i_ram_data(ram_q), .o_char(ch), .o_column(cl), .o_row(rw), .o_blank(bl));
  always @(posedge clk) if (rd) ram_q <= addr[7:0] ^ 8'h5A;
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h at vector %0d", tag, obs, exp, vecs);
    end
  endtask
  task automatic step(bit f_s, bit a, bit r);
    int ux, ul;
    bit it;
    pix_t p;
    if (r) begin
      frame = 0; x = 0; line = 0; act_d = 0; e_rd = 0; e_addr = 0; last = 0;
      p = '{1'b1, 8'd0, 3'd0, 3'd0};
      pq[0] = p; pq[1] = p; pq[2] = p;
    end else begin
      ux = f_s ? 0 : x;
      ul = f_s ? 0 : line;
      it = (frame || f_s) && a && ux < 640 && ul < 480;
      e_rd = it && ux % 8 == 0;
      if (e_rd) begin
        e_addr = 13'((ul / 8) * 80 + ux / 8);
        last = e_addr[7:0] ^ 8'h5A;
      end
      p = '{!it, last, 3'(ux % 8), 3'(ul % 8)};
      if (f_s) begin
        frame = 1; x = 0; line = 0;
      end else if (frame) begin
        if (a) x++;
        else if (act_d) begin x = 0; line++; end
      end
      act_d = a;
      pq[2] = pq[1]; pq[1] = pq[0]; pq[0] = p;
    end
    fs = f_s; act = a; rst = r;
    @(posedge clk); #1;
    vecs++;
    chk("ram_rd", 16'(rd), 16'(e_rd));
    chk("ram_addr", 16'(addr), 16'(e_addr));
    chk("blank", 16'(bl), 16'(pq[2].b));
    chk("char", 16'(ch), 16'(pq[2].c));
    if (!pq[2].b || r) begin
      chk("column", 16'(cl), 16'(pq[2].col));
      chk("row", 16'(rw), 16'(pq[2].row));
    end
  endtask
  task automatic run_line(int n, int gap);
    repeat (n) step(0, 1, 0);
    repeat (gap) step(0, 0, 0);
  endtask
  initial begin
    repeat (3) step(0, 0, 1);
    repeat (20) step(0, ($urandom % 2) == 1, 0);
    step(1, 0, 0);
    run_line(8, 4);
    step(1, 0, 0);
    step(0, 0, 0);
    run_line(640, 20);
    for (int l = 1; l <= 481; l++)
      run_line((l == 2) ? 660 : (l == 8 || l == 479 || l == 480) ? 640 : int'($urandom_range(1, 24)),
               int'($urandom_range(1, 6)));
    step(1, 0, 0);
    repeat (3) run_line(10, 3);
    repeat (37 * 8 + 5) step(0, 1, 0);
    step(1, 1, 0);
    repeat (30) step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    run_line(50, 3);
    step(1, 0, 0);
    repeat (100) step(0, 1, 0);
    step(0, 1, 1);
    repeat (20) step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    step(1, 0, 0);
    run_line(50, 3);
    repeat (3000) step(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 500) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
